four_bool_fitness_scorer: RTL
=============================

// Module: four_bool_fitness_scorer
// PURPOSE
// - Drives a four-input/four-output combinational candidate circuit through all 16 input vectors.
// - Waits a programmable settle time per vector, then samples the candidate's outputs.
// - Compares each sample against a target truth table and accumulates the count of matching output bits.
// - Sits between the evolution controller (start/score) and the candidate netlist (dut_in/dut_out).
// PARAMETERS
// - N_IN           4   candidate input count; 2**N_IN vectors per run.
// - N_OUT          4   candidate output count.
// - SETTLE_CYCLES  4   extra clock cycles dut_in is held before sampling (0 allowed); must exceed the candidate's worst gate-path delay.
// PORTS
// - clk                 in   1              single clock; all state changes on its rising edge.
// - rst_n               in   1              asynchronous, active-low reset.
// - start               in   1              request one scoring run; sampled only in IDLE.
// - target_table        in   N_OUT*2**N_IN  target_table[o*16+v] is the expected output o for input vector v; must be stable while busy.
// - dut_in              out  N_IN           registered vector to the candidate; bit i drives input i.
// - dut_out             in   N_OUT          candidate outputs; bit o is output o.
// - busy                out  1              high from the cycle after start is accepted until done.
// - done                out  1              one-cycle pulse; score is valid from this cycle.
// - score               out  7              matching bits, 0..64; held until the next accepted start.
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; dut_in, busy, done, score, vec and cnt all 0. Takes effect immediately, including mid-run; the run is abandoned and no done is issued.
// - FSM states: IDLE, SETTLE, SAMPLE, DONE.
// - IDLE, start=1 at edge E0: vec<=0, dut_in<=0, cnt<=SETTLE_CYCLES, score<=0, busy<=1, state<=SETTLE.
// - SETTLE: if cnt==0 then state<=SAMPLE, else cnt<=cnt-1.
// - SAMPLE: score += popcount(~(dut_out ^ target column for vec)), where the target column bit o is target_table[o*16+vec].
//   - If vec==15: state<=DONE.
//   - Otherwise: vec<=vec+1, dut_in<=vec+1, cnt<=SETTLE_CYCLES, state<=SETTLE.
// - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. done and busy are never high together.
// - Timing: vector k is sampled at edge E0+(k+1)*(SETTLE_CYCLES+2). done is high in the cycle after edge E0+16*(SETTLE_CYCLES+2); with defaults, that is the cycle after E0+96.
// - start while busy or in DONE: ignored, with no effect on the run or the score.
// - start held high continuously: a new run is accepted on the first IDLE cycle after DONE.
// - score width: 7 bits unsigned, cannot overflow (max 64).
// - vec width: N_IN bits; it never wraps within a run.
// - dut_out is treated as stable during SAMPLE; no synchronizer is provided.
// CONFIGURATION
// - Macro: SCORE_PER_OUTPUT_EN.
// - Defined:
//   - Adds output port per_out_score, N_OUT*5 bits; field o = per_out_score[o*5+:5] counts matches for output o (0..16).
//   - Cleared at reset and on start; updated in SAMPLE alongside score; held until the next accepted start.
//   - sum of all fields == score at all times.
// - Undefined: the port and its registers are absent; all other behaviour is identical.
// STRUCTURE
// - Package four_bool_pkg contains:
//   - N_IN, N_OUT, N_VEC=16 and SCORE_W=7.
//   - PER_OUT_W=5.
//   - The state enum {IDLE, SETTLE, SAMPLE, DONE}.
// - Sub-module four_bool_match_count (combinational):
//   - Inputs: dut_out and the target column.
//   - Outputs: the N_OUT-bit match mask and a 3-bit popcount.
//   - Used by the SAMPLE datapath.
// - Top level holds the FSM, vec/cnt counters and the accumulators.
// TESTING
// - Identity candidate (dut_out=dut_in) with an identity target table, start at E0 -> done in the cycle after E0+96; score=64.
// - Identity candidate with an all-inverted target -> score=0; dut_in steps 0..15, each value held for 6 cycles.
// - dut_out tied to 4'h0, target all zeros except 5 bits set -> score=59.
// - start re-asserted at E0+30 and E0+97 (while still busy or in DONE) -> ignored; exactly one done pulse, score unchanged.
// - rst_n low at E0+40 -> dut_in, busy, done, score = 0 immediately; after release and a new start -> full run; score correct.
// - SETTLE_CYCLES=0, SCORE_PER_OUTPUT_EN defined, candidate wrong on output 3 for every vector -> done in the cycle after E0+32; per_out_score={0,16,16,16}; score=48.

Source files
------------

// File: rtl/four_bool_pkg.sv
// Shared constants and state encoding for the four-input/four-output
// fitness scorer.
package four_bool_pkg;

  localparam int N_IN      = 4;
  localparam int N_OUT     = 4;
  localparam int N_VEC     = 16;
  localparam int SCORE_W   = 7;
  localparam int PER_OUT_W = 5;
  localparam int POP_W     = 3;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/four_bool_match_count.sv
// Combinational comparison of one sampled candidate output vector against
// the target column for the current input vector: per-bit match mask plus
// the number of matching bits.
module four_bool_match_count
  import four_bool_pkg::*;
(
  input  logic [N_OUT-1:0] dut_out,
  input  logic [N_OUT-1:0] target_col,
  output logic [N_OUT-1:0] match,
  output logic [POP_W-1:0] pop
);

  function automatic logic [POP_W-1:0] popcount(input logic [N_OUT-1:0] m);
    logic [POP_W-1:0] c;
    c = '0;
    for (int i = 0; i < N_OUT; i++) begin
      c = c + POP_W'(m[i]);
    end
    return c;
  endfunction

  // A bit matches when candidate and target agree.
  always_comb begin
    match = ~(dut_out ^ target_col);
    pop   = popcount(match);
  end

endmodule

// File: rtl/four_bool_fitness_scorer.sv
// Drives a 4-in/4-out candidate through all 16 input vectors, waits
// SETTLE_CYCLES extra cycles per vector, then scores the sampled outputs
// against a target truth table.
// Optional feature macro: SCORE_PER_OUTPUT_EN adds per_out_score, a
// 5-bit match count for each candidate output.
module four_bool_fitness_scorer
  import four_bool_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_OUT*N_VEC-1:0]   target_table,
  output logic [N_IN-1:0]          dut_in,
  input  logic [N_OUT-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic [SCORE_W-1:0]       score
`ifdef SCORE_PER_OUTPUT_EN
  ,
  output logic [N_OUT*PER_OUT_W-1:0] per_out_score
`endif
);

  // A zero settle time still needs a 1-bit counter that simply stays at 0.
  localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

  state_t           state;
  logic [N_IN-1:0]  vec;
  logic [CNT_W-1:0] cnt;
  logic [N_OUT-1:0] target_col;
  logic [N_OUT-1:0] match;
  logic [POP_W-1:0] pop;

  // Target column for the vector currently applied: bit o is output o.
  always_comb begin
    target_col = '0;
    for (int o = 0; o < N_OUT; o++) begin
      target_col[o] = target_table[o*N_VEC + int'(vec)];
    end
  end

  four_bool_match_count u_match (
    .dut_out    (dut_out),
    .target_col (target_col),
    .match      (match),
    .pop        (pop)
  );

`ifndef SCORE_PER_OUTPUT_EN
  // The mask only feeds the per-output counters; absorb it otherwise.
  logic unused_match;
  assign unused_match = ^match;
`endif

  // Run sequencer: step vectors, settle, sample and accumulate the score.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vec    <= '0;
      cnt    <= '0;
      dut_in <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      score  <= '0;
`ifdef SCORE_PER_OUTPUT_EN
      per_out_score <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec    <= '0;
            dut_in <= '0;
            cnt    <= CNT_INIT;
            score  <= '0;
`ifdef SCORE_PER_OUTPUT_EN
            per_out_score <= '0;
`endif
            busy   <= 1'b1;
            state  <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAMPLE: begin
          score <= score + SCORE_W'(pop);
`ifdef SCORE_PER_OUTPUT_EN
          for (int o = 0; o < N_OUT; o++) begin
            per_out_score[o*PER_OUT_W +: PER_OUT_W] <=
              per_out_score[o*PER_OUT_W +: PER_OUT_W] + PER_OUT_W'(match[o]);
          end
`endif
          if (vec == N_IN'(N_VEC - 1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            vec    <= vec + 1'b1;
            dut_in <= vec + 1'b1;
            cnt    <= CNT_INIT;
            state  <= SETTLE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
